// File: rtl/pic_pkg.sv
// Shared definitions for the PIC in-service / INTA sequencer slice.
package pic_pkg;

    // Acknowledge sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } pic_state_e;

    // Level reported in the vector when an INTA arrives with nothing requested
    localparam logic [2:0] SPURIOUS_LVL = 3'd7;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } enc8_t;

    // 8->3 priority encoder: lowest-numbered set bit wins (IR0 highest)
    function automatic enc8_t lowest_set8(input logic [7:0] v);
        enc8_t r;
        r.valid = |v;
        r.idx   = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) r.idx = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/pic_isr_reg.sv
// In-Service Register storage with EOI / AEOI clear and acknowledge set.
// Clears are evaluated against the current ISR; the set is applied last so
// a set and a clear on the same bit leave the bit set.
module pic_isr_reg
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       set_en,
    input  logic [2:0] set_lvl,
    input  logic       eoi,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       aeoi_clr,
    input  logic [2:0] aeoi_lvl,
    output logic [7:0] isr,
    output logic       hp_valid,
    output logic [2:0] hp_lvl
);

    enc8_t      hp;
    logic [7:0] clr_vec;
    logic [7:0] set_vec;
    logic [7:0] isr_d;

    // Highest-priority in-service level and the next ISR value
    always_comb begin
        hp      = lowest_set8(isr);
        clr_vec = 8'h00;
        if (eoi) begin
            if (eoi_specific)
                clr_vec = clr_vec | (8'h01 << eoi_level);
            else if (hp.valid)
                clr_vec = clr_vec | (8'h01 << hp.idx);
        end
        if (aeoi_clr)
            clr_vec = clr_vec | (8'h01 << aeoi_lvl);
        set_vec = set_en ? (8'h01 << set_lvl) : 8'h00;
        isr_d   = (isr & ~clr_vec) | set_vec;
    end

    assign hp_valid = hp.valid;
    assign hp_lvl   = hp.idx;

    // ISR storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) isr <= 8'h00;
        else          isr <= isr_d;
    end

endmodule

// File: rtl/pic_inservice_ctrl.sv
// INT request generation and two-pulse INTA sequencer. The first INTA
// moves the resolved level into service; the second drives the vector.
module pic_inservice_ctrl
    import pic_pkg::*;
#(
    parameter int VEC_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       resolved_level,
    input  logic             resolved_valid,
    input  logic             inta,
    input  logic             eoi,
    input  logic             eoi_specific,
    input  logic [2:0]       eoi_level,
    input  logic             aeoi,
    input  logic [VEC_W-1:0] vec_base,
    output logic             int_req,
    output logic [7:0]       isr,
    output logic [7:0]       irr_clear,
    output logic [7:0]       data_out,
    output logic             data_oe
);

    pic_state_e state, state_nx;
    logic [2:0] lvl_q;
    logic       spur_q;
    logic       hp_valid;
    logic [2:0] hp_lvl;
    logic       req_cond, first_ack, real_ack;
    logic       int_req_d, data_oe_d, aeoi_clr;
    logic [7:0] irr_clear_d, data_out_d;

    // Request only if nothing in service or the new level outranks it
    assign req_cond  = resolved_valid && (!hp_valid || (resolved_level < hp_lvl));
    assign first_ack = (state == ST_IDLE) && inta;
    assign real_ack  = first_ack && int_req;

    pic_isr_reg u_isr (
        .clk          (clk),
        .reset_n      (reset_n),
        .set_en       (real_ack),
        .set_lvl      (resolved_level),
        .eoi          (eoi),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .aeoi_clr     (aeoi_clr),
        .aeoi_lvl     (lvl_q),
        .isr          (isr),
        .hp_valid     (hp_valid),
        .hp_lvl       (hp_lvl)
    );

    // State register plus the level captured at the first INTA
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            lvl_q  <= 3'd0;
            spur_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (first_ack) begin
                lvl_q  <= int_req ? resolved_level : SPURIOUS_LVL;
                spur_q <= !int_req;
            end
        end
    end

    // Next state: INTA advances IDLE->ACK1->ACK2; ACK2 always returns
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (inta) state_nx = ST_ACK1;
            ST_ACK1: if (inta) state_nx = ST_ACK2;
            ST_ACK2: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        int_req_d   = (state_nx == ST_IDLE) && req_cond;
        irr_clear_d = real_ack ? (8'h01 << resolved_level) : 8'h00;
        data_oe_d   = (state == ST_ACK1) && inta;
        data_out_d  = data_oe_d ? 8'({vec_base, lvl_q}) : data_out;
        aeoi_clr    = data_oe_d && aeoi && !spur_q;
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_req   <= 1'b0;
            irr_clear <= 8'h00;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
        end else begin
            int_req   <= int_req_d;
            irr_clear <= irr_clear_d;
            data_out  <= data_out_d;
            data_oe   <= data_oe_d;
        end
    end

endmodule

// File: tb/tb_pic_inservice_ctrl.sv
// Bench for pic_inservice_ctrl: directed scenarios plus a randomized run
// compared against a cycle model built from the acknowledge rules.
module tb_pic_inservice_ctrl;

    localparam int VEC_W = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [2:0]       resolved_level;
    logic             resolved_valid;
    logic             inta;
    logic             eoi;
    logic             eoi_specific;
    logic [2:0]       eoi_level;
    logic             aeoi;
    logic [VEC_W-1:0] vec_base;
    logic             int_req;
    logic [7:0]       isr;
    logic [7:0]       irr_clear;
    logic [7:0]       data_out;
    logic             data_oe;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: m_phase counts INTA pulses of the current acknowledge
    int         m_phase;
    logic [7:0] m_isr, m_irr, m_dout;
    logic       m_int, m_oe, m_spur;
    logic [2:0] m_lvl;

    pic_inservice_ctrl #(.VEC_W(VEC_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .resolved_level (resolved_level),
        .resolved_valid (resolved_valid),
        .inta           (inta),
        .eoi            (eoi),
        .eoi_specific   (eoi_specific),
        .eoi_level      (eoi_level),
        .aeoi           (aeoi),
        .vec_base       (vec_base),
        .int_req        (int_req),
        .isr            (isr),
        .irr_clear      (irr_clear),
        .data_out       (data_out),
        .data_oe        (data_oe)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return i;
        return 8;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_isr = 8'h00; m_irr = 8'h00; m_dout = 8'h00;
        m_int = 1'b0; m_oe = 1'b0; m_spur = 1'b0; m_lvl = 3'd0;
    endtask

    // advance one clock, model follows from the inputs present at the edge
    task automatic tick();
        int         hp, nphase;
        logic       cond, n_int, n_oe;
        logic [7:0] clr, set, n_irr, n_dout;
        hp     = lowest(m_isr);
        cond   = resolved_valid && (int'(resolved_level) < hp);
        clr    = 8'h00; set = 8'h00; n_irr = 8'h00;
        n_int  = 1'b0; n_oe = 1'b0; n_dout = m_dout; nphase = m_phase;
        if (eoi) begin
            if (eoi_specific) clr = clr | (8'h01 << eoi_level);
            else if (hp < 8)  clr = clr | (8'h01 << hp);
        end
        if (m_phase == 0) begin
            if (inta) begin
                if (m_int) begin
                    m_lvl = resolved_level; m_spur = 1'b0;
                    set = 8'h01 << resolved_level; n_irr = set;
                end else begin
                    m_lvl = 3'd7; m_spur = 1'b1;
                end
                nphase = 1;
            end else n_int = cond;
        end else if (m_phase == 1) begin
            if (inta) begin
                nphase = 2; n_oe = 1'b1; n_dout = {vec_base, m_lvl};
                if (aeoi && !m_spur) clr = clr | (8'h01 << m_lvl);
            end
        end else begin
            nphase = 0; n_int = cond;
        end
        @(posedge clk); #1;
        m_isr = (m_isr & ~clr) | set;
        m_int = n_int; m_irr = n_irr; m_oe = n_oe; m_dout = n_dout; m_phase = nphase;
    endtask

    task automatic clear_inputs();
        resolved_level = 3'd0; resolved_valid = 1'b0; inta = 1'b0; eoi = 1'b0;
        eoi_specific = 1'b0; eoi_level = 3'd0; aeoi = 1'b0; vec_base = 5'h08;
    endtask

    // complete an acknowledge from IDLE: two INTA pulses with a gap
    task automatic do_ack();
        inta = 1'b1; tick(); inta = 1'b0; resolved_valid = 1'b0;
        tick();
        inta = 1'b1; tick(); inta = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear_inputs(); model_reset();
        repeat (2) @(posedge clk); #1;
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int_req got %b want 0", int_req); end
        n_checks++; if (isr !== 8'h00) begin n_fail++; $display("FAIL reset_isr got %h want 00", isr); end
        n_checks++; if (irr_clear !== 8'h00) begin n_fail++; $display("FAIL reset_irr_clear got %h want 00", irr_clear); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got %h want 00", data_out); end
        n_checks++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe got %b want 0", data_oe); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_request();
        resolved_valid = 1'b1; resolved_level = 3'd3; vec_base = 5'h08;
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL single_int_req got %b want 1", int_req); end
        inta = 1'b1; tick(); inta = 1'b0; resolved_valid = 1'b0;
        n_checks++; if (irr_clear !== 8'h08) begin n_fail++; $display("FAIL single_irr_clear got %h want 08", irr_clear); end
        n_checks++; if (isr !== 8'h08) begin n_fail++; $display("FAIL single_isr got %h want 08", isr); end
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL single_int_req_drop got %b want 0", int_req); end
        tick();
        n_checks++; if (irr_clear !== 8'h00) begin n_fail++; $display("FAIL single_irr_pulse got %h want 00", irr_clear); end
        inta = 1'b1; tick(); inta = 1'b0;
        n_checks++; if (data_oe !== 1'b1 || data_out !== 8'h43) begin n_fail++; $display("FAIL single_vector got oe=%b %h want oe=1 43", data_oe, data_out); end
        tick();
        n_checks++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL single_oe_pulse got %b want 0", data_oe); end
    endtask

    task automatic test_nesting();
        resolved_valid = 1'b1; resolved_level = 3'd5;
        tick(); tick();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_lower_blocked got %b want 0", int_req); end
        resolved_level = 3'd1;
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL nest_higher_req got %b want 1", int_req); end
        do_ack();
        n_checks++; if (isr !== 8'h0A) begin n_fail++; $display("FAIL nest_isr got %h want 0a", isr); end
        n_checks++; if (data_out !== 8'h41) begin n_fail++; $display("FAIL nest_vector got %h want 41", data_out); end
    endtask

    task automatic test_nonspecific_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_checks++; if (isr !== 8'h08) begin n_fail++; $display("FAIL eoi_first got %h want 08", isr); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_checks++; if (isr !== 8'h00) begin n_fail++; $display("FAIL eoi_second got %h want 00", isr); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_checks++; if (isr !== 8'h00) begin n_fail++; $display("FAIL eoi_empty got %h want 00", isr); end
    endtask

    task automatic test_aeoi();
        aeoi = 1'b1; resolved_valid = 1'b1; resolved_level = 3'd6; vec_base = 5'h08;
        tick();
        inta = 1'b1; tick(); inta = 1'b0; resolved_valid = 1'b0;
        n_checks++; if (isr !== 8'h40) begin n_fail++; $display("FAIL aeoi_set got %h want 40", isr); end
        tick();
        inta = 1'b1; tick(); inta = 1'b0;
        n_checks++; if (data_out !== 8'h46 || data_oe !== 1'b1) begin n_fail++; $display("FAIL aeoi_vector got oe=%b %h want oe=1 46", data_oe, data_out); end
        n_checks++; if (isr !== 8'h00) begin n_fail++; $display("FAIL aeoi_isr got %h want 00", isr); end
        tick();
        aeoi = 1'b0;
    endtask

    task automatic test_spurious();
        resolved_valid = 1'b1; resolved_level = 3'd3;
        tick(); do_ack();
        aeoi = 1'b1;
        tick();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL spur_no_req got %b want 0", int_req); end
        inta = 1'b1; tick(); inta = 1'b0;
        n_checks++; if (irr_clear !== 8'h00) begin n_fail++; $display("FAIL spur_irr_clear got %h want 00", irr_clear); end
        tick();
        inta = 1'b1; tick(); inta = 1'b0;
        n_checks++; if (data_out !== 8'h47 || data_oe !== 1'b1) begin n_fail++; $display("FAIL spur_vector got oe=%b %h want oe=1 47", data_oe, data_out); end
        n_checks++; if (isr !== 8'h08) begin n_fail++; $display("FAIL spur_isr got %h want 08", isr); end
        tick();
        aeoi = 1'b0;
        eoi = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3; tick(); eoi = 1'b0; eoi_specific = 1'b0;
        n_checks++; if (isr !== 8'h00) begin n_fail++; $display("FAIL spec_eoi got %h want 00", isr); end
    endtask

    task automatic test_reset_mid();
        resolved_valid = 1'b1; resolved_level = 3'd2;
        tick();
        inta = 1'b1; tick(); inta = 1'b0;
        reset_n = 1'b0; #2;
        n_checks++; if ({int_req, isr, irr_clear, data_out, data_oe} !== 26'd0) begin n_fail++;
            $display("FAIL midreset_outputs got req=%b isr=%h irr=%h dout=%h oe=%b want all 0", int_req, isr, irr_clear, data_out, data_oe); end
        model_reset();
        @(posedge clk); #1; reset_n = 1'b1;
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL midreset_idle_req got %b want 1", int_req); end
        inta = 1'b1; tick(); inta = 1'b0; resolved_valid = 1'b0;
        n_checks++; if (irr_clear !== 8'h04 || isr !== 8'h04) begin n_fail++; $display("FAIL midreset_reack got irr=%h isr=%h want 04 04", irr_clear, isr); end
        tick(); inta = 1'b1; tick(); inta = 1'b0; tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_collision();
        resolved_valid = 1'b1; resolved_level = 3'd2;
        tick();
        inta = 1'b1; eoi = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
        tick();
        inta = 1'b0; eoi = 1'b0; eoi_specific = 1'b0; resolved_valid = 1'b0;
        n_checks++; if (isr !== 8'h04) begin n_fail++; $display("FAIL collide_specific got %h want 04", isr); end
        tick(); inta = 1'b1; tick(); inta = 1'b0; tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        resolved_valid = 1'b1; resolved_level = 3'd4;
        tick(); do_ack();
        resolved_valid = 1'b1; resolved_level = 3'd2;
        tick();
        inta = 1'b1; eoi = 1'b1;
        tick();
        inta = 1'b0; eoi = 1'b0; resolved_valid = 1'b0;
        n_checks++; if (isr !== 8'h04) begin n_fail++; $display("FAIL collide_nonspecific got %h want 04", isr); end
        tick(); inta = 1'b1; tick(); inta = 1'b0; tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_back_to_back();
        resolved_valid = 1'b1; resolved_level = 3'd0; vec_base = 5'h1F;
        tick();
        inta = 1'b1; tick(); tick(); tick(); inta = 1'b0; resolved_valid = 1'b0;
        n_checks++; if (data_oe !== 1'b0 || data_out !== 8'hF8) begin n_fail++; $display("FAIL b2b_vector got oe=%b %h want oe=0 f8", data_oe, data_out); end
        n_checks++; if (isr !== 8'h01 || int_req !== 1'b0) begin n_fail++; $display("FAIL b2b_state got isr=%h req=%b want 01 0", isr, int_req); end
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            resolved_valid = ($urandom_range(0, 1) == 1);
            resolved_level = 3'($urandom_range(0, 7));
            inta           = ($urandom_range(0, 2) == 0);
            eoi            = ($urandom_range(0, 5) == 0);
            eoi_specific   = ($urandom_range(0, 1) == 1);
            eoi_level      = 3'($urandom_range(0, 7));
            aeoi           = ($urandom_range(0, 3) == 0);
            vec_base       = 5'($urandom_range(0, 31));
            tick();
            n_checks++; if (int_req !== m_int) begin n_fail++; $display("FAIL rand_int_req cyc %0d got %b want %b", c, int_req, m_int); end
            n_checks++; if (isr !== m_isr) begin n_fail++; $display("FAIL rand_isr cyc %0d got %h want %h", c, isr, m_isr); end
            n_checks++; if (irr_clear !== m_irr) begin n_fail++; $display("FAIL rand_irr_clear cyc %0d got %h want %h", c, irr_clear, m_irr); end
            n_checks++; if (data_oe !== m_oe) begin n_fail++; $display("FAIL rand_data_oe cyc %0d got %b want %b", c, data_oe, m_oe); end
            n_checks++; if (data_out !== m_dout) begin n_fail++; $display("FAIL rand_data_out cyc %0d got %h want %h", c, data_out, m_dout); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_nesting();
        test_nonspecific_eoi();
        test_aeoi();
        test_spurious();
        test_reset_mid();
        test_collision();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
